// File: rtl/line_buffer_ctrl_pkg.sv
// Shared definitions for the line buffer controller: FSM state encoding,
// default geometry, padded-dimension constants and a counter-width helper.
// No logic; pure declarations.
package line_buffer_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Default geometry: 3x3 kernel over a 5x5 fmap with one pixel of padding
    localparam int DEF_KH    = 3;
    localparam int DEF_KW    = 3;
    localparam int DEF_H     = 5;
    localparam int DEF_W     = 5;
    localparam int DEF_PAD_H = 1;
    localparam int DEF_PAD_W = 1;

    localparam int DEF_PADDED_H = DEF_H + 2 * DEF_PAD_H;
    localparam int DEF_PADDED_W = DEF_W + 2 * DEF_PAD_W;

    // Bits needed to count 0..n-1 (never less than one bit)
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/padded_raster_cnt.sv
// Row-major raster position counter over the padded frame; flags padding,
// window-complete and last position for the current (not yet shifted) slot.
// Latency: flags are combinational from the counters; counters step on adv.
// Backpressure: the counter holds whenever adv is low.
// Ports: clk, rst (async, active-high), adv (position consumed this cycle),
//        pad / win / last (properties of the current position).
// Optional: LINE_BUFFER_CTRL_STRIDE_EN adds stride_h/stride_w phase gating.
module padded_raster_cnt
    import line_buffer_ctrl_pkg::*;
#(
    parameter int Kh    = DEF_KH,
    parameter int Kw    = DEF_KW,
    parameter int h     = DEF_H,
    parameter int w     = DEF_W,
    parameter int pad_h = DEF_PAD_H,
    parameter int pad_w = DEF_PAD_W
`ifdef LINE_BUFFER_CTRL_STRIDE_EN
    ,
    parameter int stride_h = 1,
    parameter int stride_w = 1
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic adv,
    output logic pad,
    output logic win,
    output logic last
);

    localparam int PH = h + 2 * pad_h;
    localparam int PW = w + 2 * pad_w;
    localparam int RW = cnt_w(PH);
    localparam int CW = cnt_w(PW);

    localparam logic [RW-1:0] ROW_LAST = RW'(PH - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(PW - 1);
    localparam logic [RW-1:0] ROW_TOP  = RW'(pad_h);
    localparam logic [RW-1:0] ROW_BOT  = RW'(h + pad_h);
    localparam logic [CW-1:0] COL_LFT  = CW'(pad_w);
    localparam logic [CW-1:0] COL_RGT  = CW'(w + pad_w);
    // First row/col at which a full kernel footprint has been shifted in
    localparam logic [RW-1:0] ROW_WIN  = RW'(Kh - 1);
    localparam logic [CW-1:0] COL_WIN  = CW'(Kw - 1);

    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          phase_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (adv) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    assign pad  = (row < ROW_TOP) || (row >= ROW_BOT) ||
                  (col < COL_LFT) || (col >= COL_RGT);
    assign last = (row == ROW_LAST) && (col == COL_LAST);

`ifdef LINE_BUFFER_CTRL_STRIDE_EN
    // Distance from the first window anchor; only valid when win gating passes
    logic [RW-1:0] row_ph;
    logic [CW-1:0] col_ph;
    assign row_ph   = row - ROW_WIN;
    assign col_ph   = col - COL_WIN;
    assign phase_ok = ((row_ph % RW'(stride_h)) == '0) &&
                      ((col_ph % CW'(stride_w)) == '0);
`else
    assign phase_ok = 1'b1;
`endif

    assign win = (row >= ROW_WIN) && (col >= COL_WIN) && phase_ok;

endmodule

// File: rtl/line_buffer_ctrl.sv
// Line buffer sequencer: rasters the padded frame, injecting zero shifts at
// padding positions and pixel shifts at interior positions, and flags when
// the sliding window holds a complete kernel footprint.
// Latency: out_valid rises the cycle after the completing shift.
// Backpressure: a held window (out_valid & ~out_ready) freezes shifting and
// input consumption; in_valid low at interior positions simply waits.
// Ports: clk, rst (async, active-high), start, in_valid/in_ready (pixel in),
//        lb_valid/lb_zero (line buffer shift/zero), out_valid/out_ready
//        (window out), busy, done (one-cycle end-of-frame pulse).
// Optional: LINE_BUFFER_CTRL_STRIDE_EN adds stride_h/stride_w parameters.
module line_buffer_ctrl
    import line_buffer_ctrl_pkg::*;
#(
    parameter int Kh    = DEF_KH,
    parameter int Kw    = DEF_KW,
    parameter int h     = DEF_H,
    parameter int w     = DEF_W,
    parameter int pad_h = DEF_PAD_H,
    parameter int pad_w = DEF_PAD_W
`ifdef LINE_BUFFER_CTRL_STRIDE_EN
    ,
    parameter int stride_h = 1,
    parameter int stride_w = 1
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic in_valid,
    output logic in_ready,
    output logic lb_valid,
    output logic lb_zero,
    output logic out_valid,
    input  logic out_ready,
    output logic busy,
    output logic done
);

    state_t state;
    logic   pos_pad;
    logic   pos_win;
    logic   pos_last;
    logic   stall;
    logic   run;

    padded_raster_cnt #(
        .Kh       (Kh),
        .Kw       (Kw),
        .h        (h),
        .w        (w),
        .pad_h    (pad_h),
        .pad_w    (pad_w)
`ifdef LINE_BUFFER_CTRL_STRIDE_EN
        ,
        .stride_h (stride_h),
        .stride_w (stride_w)
`endif
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .adv  (lb_valid),
        .pad  (pos_pad),
        .win  (pos_win),
        .last (pos_last)
    );

    // A presented-but-unaccepted window must not be overwritten by a shift
    assign stall    = out_valid & ~out_ready;
    assign run      = (state == RUN);
    assign lb_zero  = run & pos_pad & ~stall;
    assign in_ready = run & ~pos_pad & ~stall;
    assign lb_valid = lb_zero | (in_ready & in_valid);
    assign busy     = (state != IDLE);
    assign done     = (state == DRAIN) & ~out_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            // A new window completing takes priority over the acceptance clear
            if (lb_valid && pos_win) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE:    if (start) state <= RUN;
                RUN:     if (lb_valid && pos_last) state <= DRAIN;
                DRAIN:   if (!out_valid) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
module tb_line_buffer_ctrl;

`ifdef LINE_BUFFER_CTRL_STRIDE_EN
    localparam int SH = 2;
    localparam int SW = 2;
`else
    localparam int SH = 1;
    localparam int SW = 1;
`endif
    localparam int PH   = 7;
    localparam int PW   = 7;
    localparam int NPOS = PH * PW;
    localparam int NWIN = ((PH - 3) / SH + 1) * ((PW - 3) / SW + 1);

    logic clk = 1'b0;
    logic rst, start, in_valid, in_ready, lb_valid, lb_zero;
    logic out_valid, out_ready, busy, done;

    always #5 clk = ~clk;

    line_buffer_ctrl #(
        .Kh       (3),
        .Kw       (3),
        .h        (5),
        .w        (5),
        .pad_h    (1),
        .pad_w    (1)
`ifdef LINE_BUFFER_CTRL_STRIDE_EN
        ,
        .stride_h (SH),
        .stride_w (SW)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .lb_valid  (lb_valid),
        .lb_zero   (lb_zero),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_pad(input int p);
        int r, c;
        r = p / PW;
        c = p % PW;
        return (r < 1) || (r >= 6) || (c < 1) || (c >= 6);
    endfunction

    function automatic bit is_win(input int p);
        int r, c;
        r = p / PW;
        c = p % PW;
        return (r >= 2) && (c >= 2) && ((r - 2) % SH == 0) && ((c - 2) % SW == 0);
    endfunction

    // Golden 3x3 window of the padded image, pixel k (row-major) = k+1
    function automatic logic [71:0] golden(input int tr, input int tc);
        logic [71:0] g;
        int r, c, v;
        g = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                r = tr + i;
                c = tc + j;
                v = is_pad(r * PW + c) ? 0 : (r - 1) * 5 + (c - 1) + 1;
                g = {g[63:0], 8'(v)};
            end
        end
        return g;
    endfunction

    // Scoreboard and line buffer model
    logic [71:0] exp_q[$];
    logic [7:0]  hist[0:NPOS-1];
    int n = 0, pix = 0, last_p = 0, first_n = -1;
    bit exp_ov = 1'b0, seen_out = 1'b0, nxt;
    int tot_shift = 0, tot_zero = 0, tot_cons = 0, tot_out = 0, tot_done = 0;

    always @(negedge clk) begin
        if (rst) begin
            n = 0;
            pix = 0;
            exp_ov = 1'b0;
            seen_out = 1'b0;
        end else begin
            check("out_valid_model", 72'(out_valid), 72'(exp_ov));
            check("lb_valid_rule", 72'(lb_valid), 72'(lb_zero | (in_valid & in_ready)));
            if (out_valid && !out_ready)
                check("stall_hold", {70'd0, lb_valid, in_ready}, 72'd0);
            if (out_valid && !seen_out) begin
                seen_out = 1'b1;
                first_n = n;
            end
            if (out_valid && out_ready) begin
                logic [71:0] obs;
                int r, c;
                tot_out++;
                check("win_avail", 72'(exp_q.size() != 0), 72'd1);
                if (exp_q.size() != 0) begin
                    r = last_p / PW;
                    c = last_p % PW;
                    obs = '0;
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            obs = {obs[63:0], hist[(r - 2 + i) * PW + (c - 2 + j)]};
                    check("window", obs, exp_q.pop_front());
                end
            end
            if (done) begin
                tot_done++;
                seen_out = 1'b0;
            end
            nxt = exp_ov;
            if (lb_valid && is_win(n)) nxt = 1'b1;
            else if (out_ready) nxt = 1'b0;
            if (lb_valid) begin
                check("pad_pos", 72'(lb_zero), 72'(is_pad(n)));
                hist[n] = lb_zero ? 8'd0 : 8'(pix + 1);
                if (lb_zero) tot_zero++;
                else begin
                    tot_cons++;
                    pix++;
                end
                tot_shift++;
                last_p = n;
                n = (n == NPOS - 1) ? 0 : n + 1;
                if (n == 0) pix = 0;
            end
            exp_ov = nxt;
        end
    end

    task automatic push_goldens();
        for (int tr = 0; tr <= PH - 3; tr += SH)
            for (int tc = 0; tc <= PW - 3; tc += SW)
                exp_q.push_back(golden(tr, tc));
    endtask

    // Runs one frame; entered and left at posedge+1
    task automatic run_frame(input bit tog, input bit stall, input bit xstart, input string tag);
        int b_shift, b_zero, b_cons, b_out, b_done;
        bit stalled;
        b_shift = tot_shift; b_zero = tot_zero; b_cons = tot_cons;
        b_out = tot_out; b_done = tot_done;
        stalled = 1'b0;
        push_goldens();
        start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 400 && tot_done == b_done; cyc++) begin
            in_valid = tog ? (cyc % 2 == 0) : 1'b1;
            start = xstart && (cyc == 10 || cyc == 30);
            if (stall && !stalled && out_valid) begin
                stalled = 1'b1;
                out_ready = 1'b0;
                repeat (10) begin
                    #1;
                    check({tag, "_stall"}, {69'd0, out_valid, lb_valid, in_ready}, 72'b100);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_done"},   72'(tot_done - b_done), 72'd1);
        check({tag, "_shifts"}, 72'(tot_shift - b_shift), 72'd49);
        check({tag, "_zeros"},  72'(tot_zero - b_zero), 72'd24);
        check({tag, "_pixels"}, 72'(tot_cons - b_cons), 72'd25);
        check({tag, "_windows"}, 72'(tot_out - b_out), 72'(NWIN));
        check({tag, "_first"},  72'(first_n), 72'd17);
        check({tag, "_q_empty"}, 72'(exp_q.size()), 72'd0);
        check({tag, "_idle"},   {70'd0, busy, out_valid}, 72'd0);
    endtask

    initial begin
        int b_shift;
        rst = 1'b1; start = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        #2;
        check("reset_outs", {66'd0, in_ready, lb_valid, lb_zero, out_valid, busy, done}, 72'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("idle_outs", {66'd0, in_ready, lb_valid, lb_zero, out_valid, busy, done}, 72'd0);

        run_frame(1'b0, 1'b0, 1'b0, "base");
        run_frame(1'b0, 1'b1, 1'b0, "stall");
        run_frame(1'b1, 1'b0, 1'b1, "toggle");

        // Abort a frame mid-way with reset
        push_goldens();
        b_shift = tot_shift;
        start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_run", 72'(busy), 72'd1);
        for (int cyc = 0; cyc < 200 && (tot_shift - b_shift) < 30; cyc++) begin
            @(posedge clk); #1;
        end
        check("rst_reach30", 72'((tot_shift - b_shift) >= 30), 72'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_outs", {66'd0, in_ready, lb_valid, lb_zero, out_valid, busy, done}, 72'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_idle", {66'd0, in_ready, lb_valid, lb_zero, out_valid, busy, done}, 72'd0);

        run_frame(1'b0, 1'b0, 1'b0, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
